// File: rtl/speedtest_readout_pkg.sv
// speedtest_readout_pkg
// Shared types and helpers for the speed-test readout stream:
//   - ser_state_t           : serializer state encoding
//   - words_per_snapshot()  : number of output words per snapshot
//   - DROP_CNT_W            : width of the saturating drop counter
`timescale 1ns/1ps

package speedtest_readout_pkg;

    localparam int DROP_CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    function automatic int words_per_snapshot(input int n_ch, input int word_w);
        return (n_ch + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/speedtest_snap_fifo.sv
// speedtest_snap_fifo
// Synchronous show-ahead FIFO holding complete snapshots.
// rdata always presents the oldest entry while empty is low.
// A push on a full FIFO is accepted only if a pop happens in the same cycle.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   push, wdata    : write request and data
//   pop, rdata     : read request and head-of-queue data
//   full, empty    : occupancy flags
//   count          : current occupancy (0..DEPTH)
`timescale 1ns/1ps

module speedtest_snap_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/speedtest_readout_stream.sv
// speedtest_readout_stream
// Periodically snapshots N_CH asynchronous comparator outputs, buffers the
// snapshots in a DEPTH-entry FIFO and streams each one as WORD_W-bit words,
// least-significant word first, over a valid/ready interface.
// Optional build macro: SPEEDTEST_TIMESTAMP_EN adds a free-running cycle
// counter latched with every snapshot and sent as a header word before word 0.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   din                  : raw comparator outputs (asynchronous)
//   enable               : sampling enable; low holds the period counter at 0
//   sample_period        : cycles between samples (0 behaves as 1)
//   dout/dout_valid/
//   dout_ready/dout_last : output word stream, dout_last on final data word
//   overflow, drop_cnt   : sticky drop flag and saturating drop count
//   clear_ovf            : synchronous clear of overflow and drop_cnt
//   fill_level           : current FIFO occupancy
`timescale 1ns/1ps

module speedtest_readout_stream
    import speedtest_readout_pkg::*;
#(
    parameter int N_CH   = 64,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 16,
    parameter int DIV_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          din,
    input  logic                     enable,
    input  logic [DIV_W-1:0]         sample_period,
    output logic [WORD_W-1:0]        dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     dout_last,
    output logic                     overflow,
    input  logic                     clear_ovf,
    output logic [DROP_CNT_W-1:0]    drop_cnt,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int NW = words_per_snapshot(N_CH, WORD_W);
`ifdef SPEEDTEST_TIMESTAMP_EN
    localparam int NWT = NW + 1;
`else
    localparam int NWT = NW;
`endif
    localparam int SNAP_W = NWT * WORD_W;
    localparam int IDX_W  = (NWT > 1) ? $clog2(NWT) : 1;

    logic [N_CH-1:0]          r_sync1;
    logic [N_CH-1:0]          r_sync2;
    logic [DIV_W-1:0]         r_period_cnt;
    logic [DIV_W-1:0]         w_period_m1;
    logic                     w_strobe;
    logic [NW*WORD_W-1:0]     w_data_pad;
    logic [SNAP_W-1:0]        w_snap;
    logic [SNAP_W-1:0]        w_rdata;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_pop;
    logic                     w_drop;
    logic                     w_accept;
    ser_state_t               r_state;
    logic [SNAP_W-1:0]        r_buf;
    logic [IDX_W-1:0]         r_idx;
    logic [WORD_W-1:0]        r_dout;
    logic                     r_dout_valid;
    logic                     r_dout_last;
    logic                     r_overflow;
    logic [DROP_CNT_W-1:0]    r_drop_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    // >= rather than == so that lowering sample_period on the fly cannot
    // leave the counter stranded above the new terminal count.
    assign w_period_m1 = (sample_period == '0) ? '0 : sample_period - 1'b1;
    assign w_strobe    = enable && (r_period_cnt >= w_period_m1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period_cnt <= '0;
        end else if (!enable || w_strobe) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + 1'b1;
        end
    end

    always_comb begin
        w_data_pad           = '0;
        w_data_pad[N_CH-1:0] = r_sync2;
    end

`ifdef SPEEDTEST_TIMESTAMP_EN
    logic [WORD_W-1:0] r_ts;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    // Timestamp occupies the least-significant word so it is sent first.
    assign w_snap = {w_data_pad, r_ts};
`else
    assign w_snap = w_data_pad;
`endif

    speedtest_snap_fifo #(
        .WIDTH (SNAP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_strobe),
        .wdata (w_snap),
        .pop   (w_pop),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (fill_level)
    );

    assign w_accept = r_dout_valid && dout_ready;
    // Pop when idle, or when the final word is being accepted so the next
    // snapshot follows without a bubble.
    assign w_pop    = !w_empty &&
                      ((r_state == IDLE) || (r_state == SEND && w_accept && r_dout_last));
    assign w_drop   = w_strobe && w_full && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_buf        <= '0;
            r_idx        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
        end else if (w_pop) begin
            r_state      <= SEND;
            r_dout       <= w_rdata[WORD_W-1:0];
            r_buf        <= w_rdata >> WORD_W;
            r_idx        <= '0;
            r_dout_valid <= 1'b1;
            r_dout_last  <= (NWT == 1);
        end else if (r_state == SEND && w_accept) begin
            if (r_dout_last) begin
                r_state      <= IDLE;
                r_dout_valid <= 1'b0;
                r_dout_last  <= 1'b0;
            end else begin
                r_dout      <= r_buf[WORD_W-1:0];
                r_buf       <= r_buf >> WORD_W;
                r_idx       <= r_idx + 1'b1;
                r_dout_last <= (r_idx == IDX_W'(NWT - 2));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clear_ovf) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_last;
    assign overflow   = r_overflow;
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_speedtest_readout_stream.sv
`timescale 1ns/1ps

module tb_speedtest_readout_stream;

    localparam int N_CH   = 64;
    localparam int WORD_W = 32;
    localparam int DEPTH  = 4;
    localparam int DIV_W  = 16;
    localparam int NW     = 2;
`ifdef SPEEDTEST_TIMESTAMP_EN
    localparam int NWT    = NW + 1;
`else
    localparam int NWT    = NW;
`endif

    logic                 clk;
    logic                 reset;
    logic [N_CH-1:0]      din;
    logic                 enable;
    logic [DIV_W-1:0]     sample_period;
    logic [WORD_W-1:0]    dout;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 dout_last;
    logic                 overflow;
    logic                 clear_ovf;
    logic [7:0]           drop_cnt;
    logic [2:0]           fill_level;

    logic [39:0]          din40;
    logic                 enable40;
    logic [WORD_W-1:0]    dout40;
    logic                 valid40;
    logic                 ready40;
    logic                 last40;
    logic                 ovf40;
    logic [7:0]           drop40;
    logic [2:0]           fill40;

    speedtest_readout_stream #(
        .N_CH(N_CH), .WORD_W(WORD_W), .DEPTH(DEPTH), .DIV_W(DIV_W)
    ) dut (
        .clk(clk), .reset(reset), .din(din), .enable(enable),
        .sample_period(sample_period), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last), .overflow(overflow),
        .clear_ovf(clear_ovf), .drop_cnt(drop_cnt), .fill_level(fill_level)
    );

    speedtest_readout_stream #(
        .N_CH(40), .WORD_W(WORD_W), .DEPTH(DEPTH), .DIV_W(DIV_W)
    ) dut40 (
        .clk(clk), .reset(reset), .din(din40), .enable(enable40),
        .sample_period(sample_period), .dout(dout40), .dout_valid(valid40),
        .dout_ready(ready40), .dout_last(last40), .overflow(ovf40),
        .clear_ovf(clear_ovf), .drop_cnt(drop40), .fill_level(fill40)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard entries: {last, data word}
    logic [32:0] sb_q[$];
    logic [31:0] hdr_q[$];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_snap(input logic [63:0] d);
        sb_q.push_back({1'b0, d[31:0]});
        sb_q.push_back({1'b1, d[63:32]});
    endtask

    // n strobes: the first lands in enabled cycle eff-1, so n*eff cycles give n.
    task automatic run_burst(input logic [63:0] d, input logic [15:0] per, input int n);
        int eff;
        eff = (per == 0) ? 1 : int'(per);
        din = d;
        step(3);
        sample_period = per;
        for (int i = 0; i < n; i++) push_snap(d);
        enable = 1'b1;
        step(n * eff);
        enable = 1'b0;
    endtask

    task automatic run_random(input logic [63:0] d, input logic [15:0] per, input int n);
        int k;
        din = d;
        step(3);
        sample_period = per;
        for (int i = 0; i < n; i++) push_snap(d);
        enable = 1'b1;
        for (int c = 0; c < n * int'(per); c++) begin
            dout_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        enable = 1'b0;
        k = 0;
        while (sb_q.size() != 0 && k < 1000) begin
            dout_ready = ($urandom_range(0, 3) != 0);
            step(1);
            k++;
        end
        dout_ready = 1'b1;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 2000) begin
            step(1);
            k++;
        end
        chk({tag, "_drain_left"}, 64'(sb_q.size()), 64'd0);
        step(3);
        chk({tag, "_idle_valid"}, dout_valid, 1'b0);
        chk({tag, "_idle_fill"}, fill_level, 3'd0);
    endtask

    // Output monitor: stall stability plus in-order word scoreboard.
    int          pos;
    logic        prev_stall;
    logic [31:0] prev_dout;
    logic        prev_last;
    logic [32:0] exp_w;

    always @(negedge clk) begin
        if (reset) begin
            pos        = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", dout_valid, 1'b1);
                chk("stall_dout", dout, prev_dout);
                chk("stall_last", dout_last, prev_last);
            end
            if (dout_valid && dout_ready) begin
`ifdef SPEEDTEST_TIMESTAMP_EN
                if (pos == 0) begin
                    hdr_q.push_back(dout);
                    chk("hdr_last", dout_last, 1'b0);
                end else
`endif
                if (sb_q.size() == 0) begin
                    chk("sb_extra_word", 64'(sb_q.size()), 64'd1);
                end else begin
                    exp_w = sb_q.pop_front();
                    chk("word", dout, exp_w[31:0]);
                    chk("last", dout_last, exp_w[32]);
                end
                pos = (pos == NWT - 1) ? 0 : pos + 1;
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            prev_last  = dout_last;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got40 [8];
        logic        gl40  [8];
        int          n40;
        int          k;
        int          off;

        reset         = 1'b1;
        din           = '0;
        enable        = 1'b0;
        sample_period = 16'd4;
        dout_ready    = 1'b1;
        clear_ovf     = 1'b0;
        din40         = '0;
        enable40      = 1'b0;
        ready40       = 1'b1;
        step(3);
        chk("rst_dout", dout, 32'd0);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_last", dout_last, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_drop", drop_cnt, 8'd0);
        chk("rst_fill", fill_level, 3'd0);
        reset = 1'b0;
        step(2);

        // Basic pattern, period 4; strobe in enabled cycle 3, valid in cycle 5.
        din = 64'hDEADBEEF_01234567;
        step(3);
        sample_period = 16'd4;
        for (int i = 0; i < 5; i++) push_snap(64'hDEADBEEF_01234567);
        enable = 1'b1;
        step(4);
        chk("lat_early_valid", dout_valid, 1'b0);
        step(1);
        chk("lat_first_valid", dout_valid, 1'b1);
`ifndef SPEEDTEST_TIMESTAMP_EN
        chk("lat_first_word", dout, 32'h01234567);
`endif
        step(15);
        enable = 1'b0;
        drain("basic");

        // Further patterns, period 0 (acts as 1), and sustained rate at period = words.
        run_burst(64'h0000_0000_FFFF_FFFF, 16'd5, 3);
        drain("pat_a");
        run_burst(64'h8000_0001_7FFF_FFFE, 16'd0, 3);
        drain("per0");
        chk("per0_ovf", overflow, 1'b0);
        run_burst(64'hA5A5_5A5A_C3C3_3C3C, 16'(NWT), 8);
        drain("sustain");
        chk("sustain_ovf", overflow, 1'b0);
        chk("sustain_drop", drop_cnt, 8'd0);

        // Random backpressure.
        for (int r = 0; r < 3; r++) begin
            run_random({$urandom, $urandom}, 16'd10, 4);
            drain("rand");
        end
        chk("rand_ovf", overflow, 1'b0);

        // Overflow: ready low throughout; 17 strobes at period 1 leave one
        // snapshot in the output register, DEPTH in the FIFO, 12 dropped.
        dout_ready = 1'b0;
        din = 64'h1111_2222_3333_4444;
        step(3);
        sample_period = 16'd1;
        for (int i = 0; i < 1 + DEPTH; i++) push_snap(64'h1111_2222_3333_4444);
        enable = 1'b1;
        step(17);
        enable = 1'b0;
        step(2);
        chk("ovf_fill", fill_level, 3'd4);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_drop", drop_cnt, 8'd12);
        clear_ovf = 1'b1;
        step(1);
        clear_ovf = 1'b0;
        chk("clr_flag", overflow, 1'b0);
        chk("clr_drop", drop_cnt, 8'd0);
        chk("clr_fill", fill_level, 3'd4);
        dout_ready = 1'b1;
        drain("ovf");

        // clear_ovf in the same cycle as a drop: clear wins.
        dout_ready = 1'b0;
        for (int i = 0; i < 1 + DEPTH; i++) push_snap(64'h1111_2222_3333_4444);
        enable = 1'b1;
        step(6);
        chk("pre_clear_drop", drop_cnt, 8'd1);
        clear_ovf = 1'b1;
        step(1);
        clear_ovf = 1'b0;
        enable = 1'b0;
        step(1);
        chk("clrwin_flag", overflow, 1'b0);
        chk("clrwin_drop", drop_cnt, 8'd0);
        dout_ready = 1'b1;
        drain("clrwin");

        // Reset in the middle of a snapshot.
        dout_ready = 1'b0;
        din = 64'hCAFE_F00D_1234_ABCD;
        step(3);
        sample_period = 16'd4;
        push_snap(64'hCAFE_F00D_1234_ABCD);
        enable = 1'b1;
        step(4);
        enable = 1'b0;
        k = 0;
        while (!dout_valid && k < 20) begin
            step(1);
            k++;
        end
        chk("mid_valid", dout_valid, 1'b1);
        dout_ready = 1'b1;
        step(1);
        dout_ready = 1'b0;
        chk("mid_send_valid", dout_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", dout_valid, 1'b0);
        chk("mid_rst_last", dout_last, 1'b0);
        chk("mid_rst_dout", dout, 32'd0);
        chk("mid_rst_fill", fill_level, 3'd0);
        sb_q.delete();
        step(2);
        reset = 1'b0;
        dout_ready = 1'b1;
        step(1);
        run_burst(64'h0BAD_C0DE_600D_F00D, 16'd4, 2);
        drain("post_rst");

        // 40-channel instance: second word is zero-padded.
        din40 = '1;
        sample_period = 16'd4;
        step(3);
        enable40 = 1'b1;
        step(4);
        enable40 = 1'b0;
        n40 = 0;
        k = 0;
        while (n40 < NWT && k < 30) begin
            if (valid40) begin
                got40[n40] = dout40;
                gl40[n40]  = last40;
                n40++;
            end
            step(1);
            k++;
        end
        chk("n40_count", 64'(n40), 64'(NWT));
        off = NWT - NW;
        chk("n40_w0", got40[off], 32'hFFFF_FFFF);
        chk("n40_w0_last", gl40[off], 1'b0);
        chk("n40_w1", got40[off+1], 32'h0000_00FF);
        chk("n40_w1_last", gl40[off+1], 1'b1);

`ifdef SPEEDTEST_TIMESTAMP_EN
        hdr_q.delete();
        run_burst(64'h5555_AAAA_0F0F_F0F0, 16'd5, 3);
        drain("ts");
        chk("ts_hdr_count", 64'(hdr_q.size()), 64'd3);
        if (hdr_q.size() == 3) begin
            chk("ts_hdr_delta1", 64'(hdr_q[1] - hdr_q[0]), 64'd5);
            chk("ts_hdr_delta2", 64'(hdr_q[2] - hdr_q[1]), 64'd5);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/speedtest_readout_stream.md
# speedtest_readout_stream

Parametrised successor to the fixed 64×32 speed-test digital readout. It periodically snapshots `N_CH` asynchronous classifier comparator outputs and buffers the snapshots in a `DEPTH`-entry FIFO. It then streams each snapshot as `WORD_W`-bit words over a valid/ready interface. The block sits between the classifier array outputs and the on-chip scan/host interface, and reports overflow when snapshots are dropped.

## Interface
- `N_CH`, 64, number of comparator input channels (≥1).
- `WORD_W`, 32, output word width (≥8).
- `DEPTH`, 16, snapshot FIFO depth (power of two, ≥2).
- `DIV_W`, 16, width of the sample-period register.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `din` in N_CH: raw comparator outputs, asynchronous to `clk`.
- `enable` in 1: sampling enable.
- `sample_period` in DIV_W: cycles between samples; 0 is treated as 1.
- `dout` out WORD_W: output word.
- `dout_valid` out 1: `dout` holds a valid word.
- `dout_ready` in 1: consumer accepts the word.
- `dout_last` out 1: marks the final word of a snapshot.
- `overflow` out 1: sticky flag, set when a snapshot is dropped.
- `clear_ovf` in 1: synchronous clear of `overflow` and `drop_cnt`.
- `drop_cnt` out 8: count of dropped snapshots, saturating at 255.
- `fill_level` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- `din` passes through a 2-flop synchronizer per channel.
- Period counter:
  - Counts only while `enable` is high.
  - Emits a one-cycle `strobe` when the count reaches max(`sample_period`,1)−1, then wraps to 0.
  - Deasserting `enable` resets the count to 0.
- On `strobe`, the synchronized `din` snapshot is pushed to the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the snapshot is dropped, `overflow` is set and `drop_cnt` increments.
  - A push in the same cycle as a pop on a full FIFO is accepted.
- Serializer FSM:
  - IDLE: if the FIFO is not empty, pop a snapshot, load word 0 into `dout`, assert `dout_valid`, go to SEND.
  - SEND: on `dout_valid && dout_ready`, advance the word index.
    - After the last word: if the FIFO is not empty, pop and load the next snapshot's word 0 in the same cycle (back-to-back, no bubble); otherwise return to IDLE.
- Word count is NW = ceil(N_CH/WORD_W).
  - Word k carries `din` bits [k·WORD_W +: WORD_W], least-significant word first.
  - Unused bits in the last word are zero.
- `dout_last` is high with the final word of each snapshot.
- `dout`, `dout_valid` and `dout_last` must not change while `dout_valid && !dout_ready`.
- If `clear_ovf` coincides with a drop, the clear wins and the counters read 0.

## Timing
- Reset values:
  - `dout` = 0, `dout_valid` = 0, `dout_last` = 0.
  - `overflow` = 0, `drop_cnt` = 0, `fill_level` = 0.
  - FSM = IDLE; period counter = 0.
- A `din` change is visible in the sampled value at the strobe 2 cycles later (synchronizer delay).
- With the strobe in cycle S and the serializer idle and the FIFO empty: FIFO write at end of S, pop at end of S+1, `dout_valid` = 1 in S+2.
- Maximum throughput is one word per cycle with `dout_ready` held high.
- Sustained drop-free sampling requires `sample_period` ≥ NW (NW+1 with `TIMESTAMP_EN`).
- Reset asserted mid-stream clears outputs immediately. The partial snapshot and all FIFO contents are discarded, and no completion is emitted.

## Configuration
- `SPEEDTEST_TIMESTAMP_EN`: when defined, a free-running WORD_W-bit cycle counter (reset to 0) is latched on each strobe and stored with the snapshot.
  - The timestamp is emitted as an extra header word before word 0, so NW becomes NW+1.
  - `dout_last` is still asserted only on the final data word.
- Without the macro, there is no timestamp counter and no header word.

## Structure
- Package `speedtest_readout_pkg` holds:
  - the serializer state enum {IDLE, SEND};
  - a `words_per_snapshot(N_CH, WORD_W)` function;
  - the drop-counter width constant (8).
- Sub-module `speedtest_snap_fifo` is a synchronous FIFO, parametrised by width and depth.
  - Ports: push, pop, full, empty, count.
  - Same clock and asynchronous reset as the top.
- The synchronizer, period counter and serializer live in the top.

## Test plan
- N_CH=64, WORD_W=32, period=4, `dout_ready`=1, `din`=64'hDEADBEEF_01234567 → per snapshot, words 0x01234567 then 0xDEADBEEF with `dout_last` on the second; the first `dout_valid` comes 2 cycles after the strobe.
- N_CH=40, WORD_W=32, `din`=all ones → words 0xFFFFFFFF then 0x000000FF.
- DEPTH=4, period=1, `dout_ready`=0 for 20 cycles → `fill_level`=4, `overflow`=1, `drop_cnt`=12; `clear_ovf` → both read 0.
- `dout_ready` toggled randomly → `dout` stays stable while stalled, and no word is lost or duplicated (scoreboard).
- `reset` pulsed mid-SEND → `dout_valid`=0 at once; after release the first output is a fresh snapshot starting at word 0.
- With `SPEEDTEST_TIMESTAMP_EN` and period=5 → consecutive header words differ by 5, and the header precedes word 0.
